// File: rtl/eva_intr_collector.sv
// rtl/eva_intr_collector.sv - interrupt collector with timestamped event queue
module eva_intr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Head entry is presented combinationally (first-word fall-through)
    assign rd_data = mem[rd_ptr];

    // Entry storage; contents are only meaningful while count is nonzero
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module eva_intr_collector #(
    parameter int INTR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 32,
    parameter int DCNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INTR_W-1:0]             intr_in,
    input  logic [INTR_W-1:0]             edge_mode,
    input  logic [INTR_W-1:0]             intr_mask,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [INTR_W-1:0]             evt_vec,
    output logic [TS_W-1:0]               evt_ts,
    output logic                          evt_ovf,
    output logic [DCNT_W-1:0]             drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 1 + TS_W + INTR_W;

    logic [INTR_W-1:0] intr_ff;
    logic [INTR_W-1:0] inflight;
    logic [INTR_W-1:0] rise;
    logic [INTR_W-1:0] trig;
    logic [INTR_W-1:0] level_set;
    logic [INTR_W-1:0] pop_clr;
    logic [TS_W-1:0]   tick;
    logic              ovf_pend;
    logic              push;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              full;
    logic [CW-1:0]     count;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     head;
    logic [EW-1:0]     head_hold;

    assign rise    = intr_in & ~intr_ff;
    assign trig    = ~intr_mask & ((edge_mode & rise) | (~edge_mode & intr_in & ~inflight));
    assign push    = |trig;
    // Full is judged on the registered count, so a same-cycle pop never rescues a push
    assign full    = (count == CW'(FIFO_DEPTH));
    assign push_ok = push & ~full;
    assign drop    = push & full;
    assign pop     = evt_valid & evt_ready;
    assign wr_data = {ovf_pend, tick, trig};

    assign level_set = push_ok ? (trig & ~edge_mode) : '0;
    assign pop_clr   = pop ? head[INTR_W-1:0] : '0;

    assign evt_valid  = (count != '0);
    assign fifo_level = count;
    assign {evt_ovf, evt_ts, evt_vec} = evt_valid ? head : head_hold;

    eva_intr_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    // Input history, free-running timestamp and level-line outstanding flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_ff  <= '0;
            tick     <= '0;
            inflight <= '0;
        end else begin
            intr_ff  <= intr_in;
            tick     <= tick + 1'b1;
            // A fresh push of a level line wins over a pop clearing the same bit
            inflight <= (inflight & ~pop_clr) | level_set;
        end
    end

    // Overflow flag for the next stored entry and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop) begin
                ovf_pend <= 1'b1;
                if (drop_cnt != {DCNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (push_ok) begin
                ovf_pend <= 1'b0;
            end
        end
    end

    // Keep the last visible head so outputs hold steady once the queue empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_hold <= '0;
        end else if (evt_valid) begin
            head_hold <= head;
        end
    end
endmodule
